mem_arbiter: RTL

- Round-robin arbiter and sequencer that shares one single-port `memory` instance (valid/ready, 16-bit data, 9-bit address) among NUM_REQ requesters.
- Runs one transaction at a time and drives the memory's valid/wr_rd/addr/wdata from registered outputs.
- Returns the completion pulse and read data to the granted requester.
- Includes a timeout so a stuck memory cannot hang the system.

---
 rtl/mem_pkg.sv | 9 +
 rtl/rr_picker.sv | 33 +++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and default sizes for the memory arbiter slice.
package mem_pkg;
  localparam int ADDR_WIDTH = 9;
  localparam int WIDTH      = 16;
  localparam int DEPTH      = 512;
  localparam int TIMEOUT    = 15;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request strictly after i_ptr,
// searching upward with wrap-around.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  logic [N-1:0][IW-1:0] w_pos;
  logic [N-1:0]         w_hit;

  // w_pos[gi] is the requester sitting gi+1 places after the pointer
  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    logic [IW:0] w_sum;
    assign w_sum      = {1'b0, i_ptr} + (IW+1)'(gi + 1);
    assign w_pos[gi]  = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : IW'(w_sum);
    assign w_hit[gi]  = i_req[w_pos[gi]];
  end

  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        o_idx = w_pos[k];
        o_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin sequencer sharing one single-port valid/ready memory among
// NUM_REQ requesters, one transaction at a time, with a BUSY timeout.
module mem_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = mem_pkg::ADDR_WIDTH,
  parameter int WIDTH      = mem_pkg::WIDTH,
  parameter int TIMEOUT    = mem_pkg::TIMEOUT
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_wr_rd_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*WIDTH-1:0]      req_wdata_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          req_err_o,
  output logic [WIDTH-1:0]              req_rdata_o,
  output logic [$clog2(NUM_REQ)-1:0]    grant_o,
  output logic                          busy_o,
  output logic                          mem_valid_o,
  output logic                          mem_wr_rd_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [WIDTH-1:0]              mem_wdata_o,
  input  logic                          mem_ready_i,
  input  logic [WIDTH-1:0]              mem_rdata_i
);
  import mem_pkg::*;

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);

  state_t              r_state;
  logic [GW-1:0]       r_ptr;
  logic [CW-1:0]       r_cnt;
  logic [GW-1:0]       r_grant;
  logic                r_busy;
  logic                r_mem_valid;
  logic                r_mem_wr_rd;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [WIDTH-1:0]    r_mem_wdata;
  logic [NUM_REQ-1:0]  r_req_ready;
  logic                r_req_err;
  logic [WIDTH-1:0]    r_req_rdata;

  logic [GW-1:0]         w_pick;
  logic                  w_any;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [WIDTH-1:0]      w_sel_wdata;
  logic                  w_sel_wr;
  logic                  w_timeout;
  logic [NUM_REQ-1:0]    w_onehot;

  rr_picker #(.N(NUM_REQ), .IW(GW)) u_picker (
    .i_req (req_valid_i),
    .i_ptr (r_ptr),
    .o_idx (w_pick),
    .o_any (w_any)
  );

  assign w_sel_addr  = req_addr_i[w_pick*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_sel_wdata = req_wdata_i[w_pick*WIDTH +: WIDTH];
  assign w_sel_wr    = req_wr_rd_i[w_pick];
  assign w_timeout   = (r_cnt == CW'(TIMEOUT - 1));
  assign w_onehot    = NUM_REQ'(1) << r_grant;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_ptr       <= GW'(NUM_REQ - 1);
      r_cnt       <= '0;
      r_grant     <= '0;
      r_busy      <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_wr_rd <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_req_ready <= '0;
      r_req_err   <= 1'b0;
      r_req_rdata <= '0;
    end else begin
      r_req_ready <= '0;
      r_req_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant     <= w_pick;
            r_mem_addr  <= w_sel_addr;
            r_mem_wr_rd <= w_sel_wr;
            if (w_sel_wr) r_mem_wdata <= w_sel_wdata;
            r_mem_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_cnt       <= '0;
            r_state     <= BUSY;
          end
        end
        BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          // a real ready wins over a timeout landing in the same cycle
          if (mem_ready_i || w_timeout) begin
            r_req_ready <= w_onehot;
            r_req_err   <= ~mem_ready_i;
            if (mem_ready_i && !r_mem_wr_rd) r_req_rdata <= mem_rdata_i;
            r_mem_valid <= 1'b0;
            r_ptr       <= r_grant;
            r_cnt       <= '0;
            r_state     <= DONE;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready_o = r_req_ready;
  assign req_err_o   = r_req_err;
  assign req_rdata_o = r_req_rdata;
  assign grant_o     = r_grant;
  assign busy_o      = r_busy;
  assign mem_valid_o = r_mem_valid;
  assign mem_wr_rd_o = r_mem_wr_rd;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
endmodule
